// File: rtl/rangefinder_vga_axi_regs.sv
// rtl/rangefinder_vga_axi_regs.sv - AXI4-Lite slave exposing four control registers to the rangefinder VGA datapath
module rangefinder_vga_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [3:0]                      reg_wr_stb
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;

    wstate_t       wstate;
    logic [DW-1:0] regs [4];
    logic [1:0]    wsel;
    logic [1:0]    rsel;
    logic          unused_inputs;

    assign wsel          = S_AXI_AWADDR[3:2];
    assign rsel          = S_AXI_ARADDR[3:2];
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign slv_reg0    = regs[0];
    assign slv_reg1    = regs[1];
    assign slv_reg2    = regs[2];
    assign slv_reg3    = regs[3];

    // Write path: both AW and W must be present before either is acknowledged.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            reg_wr_stb    <= '0;
            for (int r = 0; r < 4; r++) begin
                regs[r] <= '0;
            end
        end else begin
            reg_wr_stb <= '0;
            case (wstate)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wstate        <= W_ACCEPT;
                    end
                end
                W_ACCEPT: begin
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_WREADY  <= 1'b0;
                    // A master that withdrew VALID gets no transfer and no response.
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        for (int b = 0; b < SW; b++) begin
                            if (S_AXI_WSTRB[b]) begin
                                regs[wsel][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                            end
                        end
                        reg_wr_stb[wsel] <= 1'b1;
                        S_AXI_BVALID     <= 1'b1;
                        wstate           <= W_RESP;
                    end else begin
                        wstate <= W_IDLE;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read path samples the register array before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            if (S_AXI_ARREADY) begin
                S_AXI_ARREADY <= 1'b0;
                if (S_AXI_ARVALID) begin
                    S_AXI_RDATA  <= regs[rsel];
                    S_AXI_RVALID <= 1'b1;
                end
            end else if (S_AXI_ARVALID && !S_AXI_RVALID) begin
                S_AXI_ARREADY <= 1'b1;
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rangefinder_vga_axi_regs.sv
// tb/tb_rangefinder_vga_axi_regs.sv - scoreboard bench for rangefinder_vga_axi_regs
module tb_rangefinder_vga_axi_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  stb;

    int checks = 0;
    int errors = 0;

    logic [1:0]  q_b[$];
    logic [31:0] q_r[$];
    logic [3:0]  q_stb[$];

    always #5 clk = ~clk;

    rangefinder_vga_axi_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .slv_reg0(reg0), .slv_reg1(reg1), .slv_reg2(reg2), .slv_reg3(reg3), .reg_wr_stb(stb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a response or pulses a strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bvalid && bready) begin
                    if (q_b.size() == 0) chk("bresp_unexpected", 32'd1, 32'd0);
                    else chk("bresp", 32'(bresp), 32'(q_b.pop_front()));
                end
                if (rvalid && rready) begin
                    if (q_r.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
                    else begin
                        chk("rresp", 32'(rresp), 32'd0);
                        chk("rdata", rdata, q_r.pop_front());
                    end
                end
                if (stb != 4'b0) begin
                    if (q_stb.size() == 0) chk("stb_unexpected", 32'(stb), 32'd0);
                    else chk("reg_wr_stb", 32'(stb), 32'(q_stb.pop_front()));
                end
            end
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0:       return awready && wready;
            1:       return arready;
            2:       return !bvalid;
            default: return !rvalid;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(which) && n < 100);
        if (!cond(which)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: condition not reached within 100 cycles", name);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [3:0] exp_stb);
        q_b.push_back(2'b00);
        q_stb.push_back(exp_stb);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "wr_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(2, "bvalid_drop");
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        q_r.push_back(exp);
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        wait_for(1, "arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_for(3, "rvalid_drop");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_reg0", reg0, 32'd0);
        chk("rst_reg3", reg3, 32'd0);
        rst_n = 1'b1;

        // Basic write / readback at every offset, plus an unaligned alias read.
        do_write(4'h0, 32'h0101FFFF, 4'hF, 4'b0001);
        do_write(4'h4, 32'hABCD0001, 4'hF, 4'b0010);
        do_write(4'h8, 32'hDEAD0011, 4'hF, 4'b0100);
        do_write(4'hC, 32'hBEEF0011, 4'hF, 4'b1000);
        do_read(4'h0, 32'h0101FFFF);
        do_read(4'h4, 32'hABCD0001);
        do_read(4'h8, 32'hDEAD0011);
        do_read(4'hC, 32'hBEEF0011);
        do_read(4'h7, 32'hABCD0001);

        // Partial strobe and zero strobe.
        do_write(4'h4, 32'h11223344, 4'b0101, 4'b0010);
        do_read(4'h4, 32'hAB220044);
        do_write(4'h4, 32'hFFFFFFFF, 4'b0000, 4'b0010);
        do_read(4'h4, 32'hAB220044);

        // AW presented three cycles before W.
        q_b.push_back(2'b00);
        q_stb.push_back(4'b1000);
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_only_awready", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        wait_for(0, "aw_early_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(2, "aw_early_b");
        do_read(4'hC, 32'hCAFEF00D);

        // B back-pressure with a second write waiting.
        bready = 1'b0;
        q_b.push_back(2'b00);
        q_stb.push_back(4'b0001);
        @(posedge clk); #1;
        awaddr = 4'h0; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "bp_first_accept");
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h0BADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_bvalid_held", 32'(bvalid), 32'd1);
            chk("bp_second_blocked", 32'(awready), 32'd0);
        end
        q_b.push_back(2'b00);
        q_stb.push_back(4'b1000);
        @(posedge clk); #1;
        bready = 1'b1;
        wait_for(0, "bp_second_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(2, "bp_second_b");
        do_read(4'h0, 32'h55AA55AA);
        do_read(4'hC, 32'h0BADBEEF);

        // Read and write of reg2 completing at the same edge.
        q_r.push_back(32'hDEAD0011);
        q_b.push_back(2'b00);
        q_stb.push_back(4'b0100);
        @(posedge clk); #1;
        awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1;
        wait_for(0, "same_edge_accept");
        chk("same_edge_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_for(2, "same_edge_b");
        wait_for(3, "same_edge_r");
        do_read(4'h8, 32'h12345678);

        // Reset while BVALID is pending.
        bready = 1'b0;
        q_stb.push_back(4'b0010);
        @(posedge clk); #1;
        awaddr = 4'h4; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "rst_case_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("pending_bvalid", 32'(bvalid), 32'd1);
        chk("pending_reg1", reg1, 32'h77777777);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", 32'(bvalid), 32'd0);
        chk("midrst_reg0", reg0, 32'd0);
        chk("midrst_reg1", reg1, 32'd0);
        chk("midrst_reg2", reg2, 32'd0);
        chk("midrst_reg3", reg3, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        bready = 1'b1;
        rst_n = 1'b1;
        do_write(4'h4, 32'h00C0FFEE, 4'hF, 4'b0010);
        do_read(4'h4, 32'h00C0FFEE);
        do_read(4'h0, 32'h00000000);

        repeat (4) @(negedge clk);
        chk("final_reg1", reg1, 32'h00C0FFEE);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        chk("q_r_empty", 32'(q_r.size()), 32'd0);
        chk("q_stb_empty", 32'(q_stb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rangefinder_vga_axi_regs.md
# rangefinder_vga_axi_regs

AXI4-Lite slave register file that gives the processing system control over the rangefinder VGA datapath. It decodes four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, and honours byte strobes. It returns OKAY on every transfer and drives the register contents to the VGA logic, together with per-register write strobes. It is the responder that the block-design AXI4-Lite master BFM drives in the IP example test.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the word and bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- slv_reg0..slv_reg3  out  32 each  current register contents, driven to the VGA logic.
- reg_wr_stb  out  4  one-cycle pulse; bit n marks a completed write to register n.

## Operation
- Reset (asynchronous assert, synchronous release) clears the following to 0: all four registers, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA and reg_wr_stb. BRESP and RRESP are constant 0.
- Write channel is a three-state machine: IDLE -> ACCEPT -> RESP -> IDLE.
  - IDLE: when AWVALID and WVALID are both sampled high at a clock edge, move to ACCEPT. AW and W may arrive in either order or together; the slave waits for both and never accepts one channel without the other.
  - ACCEPT: AWREADY and WREADY are both high for exactly one cycle. At the end of that cycle, each byte of register AWADDR[3:2] whose WSTRB bit is set is written, reg_wr_stb[AWADDR[3:2]] is pulsed, BVALID is set, and the machine moves to RESP.
  - RESP: BVALID is held until BREADY is sampled high. AWREADY and WREADY stay low throughout RESP, so there is never more than one outstanding write. Return to IDLE on the BVALID & BREADY edge.
- A write with WSTRB = 0 still completes with OKAY, leaves the register unchanged, and still pulses reg_wr_stb.
- Read channel:
  - In IDLE, ARVALID sampled high with RVALID = 0 raises ARREADY for one cycle.
  - At the end of that cycle, RDATA is loaded with register ARADDR[3:2] and RVALID is set.
  - RVALID and RDATA are held stable until RREADY is sampled high.
  - While RVALID = 1, ARREADY stays low.
- Read and write channels are fully independent. A read and a write to the same register that complete at the same edge return the old value; the new value is visible from the next read.
- Address aliasing: only bits [3:2] are decoded, so an unaligned address selects the word that contains it.

## Timing
- Write latency: with AWVALID and WVALID high at edge k and BREADY held high:
  - AWREADY and WREADY are high in cycle k+1.
  - The register output, the reg_wr_stb pulse and BVALID all appear after edge k+1.
  - BVALID drops after edge k+2.
  - The next write can be accepted with AWREADY/WREADY high no earlier than cycle k+4.
- Read latency: with ARVALID high at edge k and RREADY held high:
  - ARREADY is high in cycle k+1.
  - RVALID and RDATA are valid after edge k+1.
  - RVALID drops after edge k+2.
- Back-pressure: if BREADY or RREADY is held low for N cycles, BVALID or RVALID stays high for those N cycles with unchanged RDATA.
- Reset mid-transaction: all handshake outputs drop immediately and no partial write lands. The register holds either 0 from reset or its last completed value.
- Master drops VALID before READY: no transfer occurs and the machine remains in IDLE. Masters must not do this; the behaviour is defined here only so the block stays deadlock-free.

## Test plan
- Write then read back, with BREADY and RREADY held high, at offsets 0x0, 0x4, 0x8 and 0xC using data 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011. Every BRESP and RRESP is 00, every readback matches, and the matching reg_wr_stb bits 0-3 each pulse once.
- Write 0x11223344 to 0x4 with WSTRB = 4'b0101, after reg1 already holds 0xABCD0001. Readback is 0xAB220044.
- AWVALID asserted 3 cycles before WVALID. AWREADY stays low until WVALID is also high; the write then completes normally.
- Hold BREADY low for 5 cycles after a write. BVALID stays high for those 5 cycles, and a second write presented meanwhile is not accepted until after the B handshake.
- Read and write of reg2 complete at the same edge (old value 0xDEAD0011, new value 0x12345678). The read returns 0xDEAD0011 and the following read returns 0x12345678.
- Deassert S_AXI_ARESETN during a pending BVALID. BVALID and all registers are 0 immediately, and a write issued after reset release succeeds.
